catch_scorer: RTL and testbench
===============================

// Module: catch_scorer
// PURPOSE
//  Score stage of the meatsquares game. Sits downstream of the sky block (ground vector) and the catcher
//  (mouse_position), and upstream of the VGA select mux. Once per frame it checks every lane with a landed
//  square against the catcher span, keeps a 3-digit BCD score and a miss count, and raises game_over.
//  On request it rasterises the score panel one pixel per clock for the vga_adapter.
// PARAMETERS
//  LANES       60   number of ground lanes; bit i covers x = LANE_W*i .. LANE_W*i+LANE_W-1
//  LANE_W      2    lane width in pixels
//  CATCH_W     16   catcher width in pixels, span [pos, pos+CATCH_W-1]
//  MAX_MISSES  3    misses allowed before game_over
//  SCORE_X     128  panel left x (8-bit)
//  SCORE_Y     4    panel top y (7-bit)
// PORTS
//  clock           in   1   system clock (CLOCK_50)
//  reset           in   1   asynchronous, active-high
//  update          in   1   1-cycle pulse: ground/mouse_position valid this cycle
//  ground          in   60  bit i = square landed in lane i this frame
//  mouse_position  in   9   catcher left x, 0..511
//  draw            in   1   level from control: rasterise panel
//  x               out  8   pixel x
//  y               out  7   pixel y
//  color           out  3   pixel colour {R,G,B}
//  finish_drawing  out  1   1-cycle pulse after last pixel
//  score           out  12  BCD {hundreds,tens,ones}
//  misses          out  2   miss count, saturates at MAX_MISSES
//  game_over       out  1   high while misses == MAX_MISSES
//  busy            out  1   scan FSM not idle
// BEHAVIOUR
//  Reset (async, any state): both FSMs -> idle; x,y,color,score,misses,finish_drawing,game_over,busy = 0.
//  Scan FSM S_IDLE/S_SCAN:
//   - S_IDLE + update: latch ground and mouse_position, lane index i = 0, busy = 1, -> S_SCAN.
//   - S_SCAN: one lane per clock, i = 0..LANES-1; after lane LANES-1 -> S_IDLE, busy = 0.
//     Update pulse at edge k: lane i is evaluated at edge k+1+i; busy is low after edge k+LANES.
//   - update while busy: dropped, latched values unchanged.
//   - Lane hit test, 10-bit unsigned, no wrap: caught iff
//     LANE_W*i+LANE_W-1 >= pos && LANE_W*i <= pos+CATCH_W-1.
//   - Set bit + caught + !game_over: BCD increment; each digit wraps 9 -> 0 with carry; 999 saturates.
//   - Set bit + not caught: misses++ (saturating); game_over = (misses == MAX_MISSES).
//   - game_over set: catches are ignored; only reset clears it.
//  Draw FSM D_IDLE/D_PIX/D_DONE/D_WAIT:
//   - D_IDLE + draw: snapshot score and misses, cx = cy = 0, -> D_PIX.
//   - D_PIX: raster is 12x7, row-major, one pixel per clock. Outputs are registered:
//     x = SCORE_X+cx, y = SCORE_Y+cy. After (11,6) -> D_DONE.
//   - D_DONE: finish_drawing = 1 for exactly 1 clock, -> D_WAIT.
//   - D_WAIT: stay until draw == 0, then -> D_IDLE. No re-arm while draw is held.
//   - draw dropping mid-raster: raster still completes.
//   - Rows 0-4: digit d = cx/4 (0 = hundreds), col = cx%4, col 3 = spacing, drawn black.
//     Glyphs are a 3x5 font: row r is 3 bits, bit 2 = leftmost; a set bit draws 3'b111, a clear bit 3'b000.
//     Glyph '0' = 111,101,101,101,111. Glyph '1' = 010,110,010,010,111.
//   - Row 5: all black.
//   - Row 6: cx < MAX_MISSES -> 3'b100 if cx < misses, else 3'b010; otherwise black.
//   - x, y, color hold their last values outside D_PIX.
//   - The scan and draw FSMs run independently; draw uses its snapshot.
// TESTING
//  T1 reset; ground=1<<10, pos=16, update -> 61 clk later score=12'h001, misses=0, busy=0.
//  T2 three frames ground=1<<0, pos=16 -> misses=3, game_over=1; then ground=1<<10, pos=16 -> score unchanged.
//  T3 catches from 12'h099 -> 12'h100; from 12'h999 -> 12'h999.
//  T4 edges: pos=104, ground=1<<59 -> catch; pos=105 -> catch; pos=120 -> miss; pos=500 -> miss.
//  T5 score=12'h001, draw=1 -> 84 pixels starting (128,4); pixel (137,4)=3'b111, (136,4)=3'b000;
//     finish_drawing is high 1 clk after the last pixel; no 2nd raster until draw drops and rises.
//  T6 second update mid-scan ignored; reset asserted mid-scan and mid-raster -> all outputs 0, next update scores cleanly.

Source files
------------

// File: rtl/catch_scorer.sv
// Score stage for meatsquares: per-frame lane hit test, BCD score, misses,
// and a 12x7 score panel rasteriser feeding the VGA adapter.
module catch_scorer #(
    parameter int         LANES      = 60,
    parameter int         LANE_W     = 2,
    parameter int         CATCH_W    = 16,
    parameter int         MAX_MISSES = 3,
    parameter logic [7:0] SCORE_X    = 8'd128,
    parameter logic [6:0] SCORE_Y    = 7'd4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             update,
    input  logic [LANES-1:0] ground,
    input  logic [8:0]       mouse_position,
    input  logic             draw,
    output logic [7:0]       x,
    output logic [6:0]       y,
    output logic [2:0]       color,
    output logic             finish_drawing,
    output logic [11:0]      score,
    output logic [1:0]       misses,
    output logic             game_over,
    output logic             busy
);
    localparam int IW = $clog2(LANES);

    typedef enum logic {S_IDLE, S_SCAN} scan_t;
    typedef enum logic [1:0] {D_IDLE, D_PIX, D_DONE, D_WAIT} draw_t;

    scan_t            state_q, state_d;
    logic [IW-1:0]    i_q, i_d;
    logic [LANES-1:0] ground_q, ground_d;
    logic [8:0]       pos_q, pos_d;
    logic             busy_q, busy_d;
    logic [11:0]      score_q, score_d;
    logic [1:0]       misses_q, misses_d;
    logic             game_over_q, game_over_d;

    logic [9:0] lane_lo, lane_hi, pos_hi;
    logic       caught;

    function automatic logic [11:0] bcd_inc(input logic [11:0] s);
        logic [3:0] h, t, o;
        {h, t, o} = s;
        if (s == 12'h999) return s;
        if (o == 4'd9) begin
            o = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            o = o + 4'd1;
        end
        return {h, t, o};
    endfunction

    // Inclusive span overlap, evaluated in 10 bits so pos+CATCH_W-1 never wraps.
    always_comb begin
        lane_lo = 10'(i_q) * 10'(LANE_W);
        lane_hi = lane_lo + 10'(LANE_W - 1);
        pos_hi  = {1'b0, pos_q} + 10'(CATCH_W - 1);
        caught  = (lane_hi >= {1'b0, pos_q}) && (lane_lo <= pos_hi);
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        ground_d    = ground_q;
        pos_d       = pos_q;
        busy_d      = busy_q;
        score_d     = score_q;
        misses_d    = misses_q;
        game_over_d = game_over_q;
        unique case (state_q)
            S_IDLE: begin
                if (update) begin
                    ground_d = ground;
                    pos_d    = mouse_position;
                    i_d      = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (ground_q[i_q]) begin
                    if (caught) begin
                        if (!game_over_q) score_d = bcd_inc(score_q);
                    end else begin
                        if (misses_q != 2'(MAX_MISSES))
                            misses_d = misses_q + 2'd1;
                        game_over_d = (misses_d == 2'(MAX_MISSES));
                    end
                end
                if (i_q == IW'(LANES - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            ground_q    <= '0;
            pos_q       <= '0;
            busy_q      <= 1'b0;
            score_q     <= '0;
            misses_q    <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            ground_q    <= ground_d;
            pos_q       <= pos_d;
            busy_q      <= busy_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            game_over_q <= game_over_d;
        end
    end

    draw_t       dstate_q, dstate_d;
    logic [3:0]  cx_q, cx_d;
    logic [2:0]  cy_q, cy_d;
    logic [11:0] snap_score_q, snap_score_d;
    logic [1:0]  snap_misses_q, snap_misses_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  color_q, color_d;
    logic        fin_q, fin_d;

    logic [3:0]  digit;
    logic [14:0] glyph;
    logic [2:0]  row;
    logic        lit;
    logic [2:0]  pix;

    function automatic logic [14:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 15'b111_101_101_101_111;
            4'd1:    font = 15'b010_110_010_010_111;
            4'd2:    font = 15'b111_001_111_100_111;
            4'd3:    font = 15'b111_001_111_001_111;
            4'd4:    font = 15'b101_101_111_001_001;
            4'd5:    font = 15'b111_100_111_001_111;
            4'd6:    font = 15'b111_100_111_101_111;
            4'd7:    font = 15'b111_001_001_001_001;
            4'd8:    font = 15'b111_101_111_101_111;
            4'd9:    font = 15'b111_101_111_001_111;
            default: font = 15'b0;
        endcase
    endfunction

    always_comb begin
        case (cx_q[3:2])
            2'd0:    digit = snap_score_q[11:8];
            2'd1:    digit = snap_score_q[7:4];
            default: digit = snap_score_q[3:0];
        endcase
        glyph = font(digit);
        case (cy_q)
            3'd0:    row = glyph[14:12];
            3'd1:    row = glyph[11:9];
            3'd2:    row = glyph[8:6];
            3'd3:    row = glyph[5:3];
            3'd4:    row = glyph[2:0];
            default: row = 3'b000;
        endcase
        case (cx_q[1:0])
            2'd0:    lit = row[2];
            2'd1:    lit = row[1];
            2'd2:    lit = row[0];
            default: lit = 1'b0;
        endcase
        pix = 3'b000;
        if (cy_q <= 3'd4) begin
            if (lit) pix = 3'b111;
        end else if (cy_q == 3'd6) begin
            if (cx_q < 4'(MAX_MISSES))
                pix = (cx_q < {2'b00, snap_misses_q}) ? 3'b100 : 3'b010;
        end
    end

    always_comb begin
        dstate_d      = dstate_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        snap_score_d  = snap_score_q;
        snap_misses_d = snap_misses_q;
        x_d           = x_q;
        y_d           = y_q;
        color_d       = color_q;
        fin_d         = 1'b0;
        unique case (dstate_q)
            D_IDLE: begin
                if (draw) begin
                    snap_score_d  = score_q;
                    snap_misses_d = misses_q;
                    cx_d          = '0;
                    cy_d          = '0;
                    dstate_d      = D_PIX;
                end
            end
            D_PIX: begin
                x_d     = SCORE_X + {4'b0000, cx_q};
                y_d     = SCORE_Y + {4'b0000, cy_q};
                color_d = pix;
                if (cx_q == 4'd11) begin
                    cx_d = '0;
                    if (cy_q == 3'd6) dstate_d = D_DONE;
                    else cy_d = cy_q + 3'd1;
                end else begin
                    cx_d = cx_q + 4'd1;
                end
            end
            D_DONE: begin
                fin_d    = 1'b1;
                dstate_d = D_WAIT;
            end
            D_WAIT: begin
                if (!draw) dstate_d = D_IDLE;
            end
            default: dstate_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dstate_q      <= D_IDLE;
            cx_q          <= '0;
            cy_q          <= '0;
            snap_score_q  <= '0;
            snap_misses_q <= '0;
            x_q           <= '0;
            y_q           <= '0;
            color_q       <= '0;
            fin_q         <= 1'b0;
        end else begin
            dstate_q      <= dstate_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            snap_score_q  <= snap_score_d;
            snap_misses_q <= snap_misses_d;
            x_q           <= x_d;
            y_q           <= y_d;
            color_q       <= color_d;
            fin_q         <= fin_d;
        end
    end

    assign x              = x_q;
    assign y              = y_q;
    assign color          = color_q;
    assign finish_drawing = fin_q;
    assign score          = score_q;
    assign misses         = misses_q;
    assign game_over      = game_over_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_catch_scorer.sv
// Directed bench for catch_scorer: scoring, misses, edges, raster, resets.
module tb_catch_scorer;
    logic        clock = 1'b0;
    logic        reset;
    logic        update;
    logic [59:0] ground;
    logic [8:0]  mouse_position;
    logic        draw;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color;
    logic        finish_drawing;
    logic [11:0] score;
    logic [1:0]  misses;
    logic        game_over;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] px [84];
    logic [6:0] py [84];
    logic [2:0] pc [84];

    catch_scorer dut (
        .clock(clock), .reset(reset), .update(update), .ground(ground),
        .mouse_position(mouse_position), .draw(draw), .x(x), .y(y),
        .color(color), .finish_drawing(finish_drawing), .score(score),
        .misses(misses), .game_over(game_over), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic pulse(input logic [59:0] g, input logic [8:0] p);
        @(negedge clock);
        ground = g;
        mouse_position = p;
        update = 1'b1;
        @(posedge clock);
        #1 update = 1'b0;
    endtask

    task automatic frame(input logic [59:0] g, input logic [8:0] p);
        pulse(g, p);
        repeat (60) @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        update = 1'b0;
        draw = 1'b0;
        ground = '0;
        mouse_position = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_color", 32'(color), 0);
        chk("rst_fin", 32'(finish_drawing), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_misses", 32'(misses), 0);
        chk("rst_go", 32'(game_over), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clock);
        reset = 1'b0;

        // T1: single catch, busy timing
        pulse(60'd1 << 10, 9'd16);
        chk("t1_busy_on", 32'(busy), 1);
        repeat (59) @(posedge clock);
        #1 chk("t1_busy_59", 32'(busy), 1);
        @(posedge clock);
        #1;
        chk("t1_busy_off", 32'(busy), 0);
        chk("t1_score", 32'(score), 32'h001);
        chk("t1_misses", 32'(misses), 0);

        // T2: three misses then a catch is ignored
        frame(60'd1, 9'd16);
        chk("t2_m1", 32'(misses), 1);
        chk("t2_go1", 32'(game_over), 0);
        frame(60'd1, 9'd16);
        chk("t2_m2", 32'(misses), 2);
        frame(60'd1, 9'd16);
        chk("t2_m3", 32'(misses), 3);
        chk("t2_go3", 32'(game_over), 1);
        frame(60'd1 << 10, 9'd16);
        chk("t2_score_frozen", 32'(score), 32'h001);
        frame(60'd1, 9'd16);
        chk("t2_m_sat", 32'(misses), 3);

        // T3: BCD carry and saturation, 8 catches per frame at pos 0
        apply_reset();
        for (int f = 0; f < 12; f++) frame(60'hFF, 9'd0);
        chk("t3_96", 32'(score), 32'h096);
        frame(60'h7, 9'd0);
        chk("t3_99", 32'(score), 32'h099);
        frame(60'h1, 9'd0);
        chk("t3_100", 32'(score), 32'h100);
        for (int f = 0; f < 112; f++) frame(60'hFF, 9'd0);
        chk("t3_996", 32'(score), 32'h996);
        frame(60'h7, 9'd0);
        chk("t3_999", 32'(score), 32'h999);
        frame(60'hFF, 9'd0);
        chk("t3_sat", 32'(score), 32'h999);
        chk("t3_misses", 32'(misses), 0);

        // T4: span edges
        apply_reset();
        frame(60'd1 << 59, 9'd104);
        chk("t4_104", 32'(score), 32'h001);
        frame(60'd1 << 59, 9'd105);
        chk("t4_105", 32'(score), 32'h002);
        frame(60'd1 << 8, 9'd1);
        chk("t4_lo_edge", 32'(score), 32'h003);
        frame(60'd1 << 59, 9'd120);
        chk("t4_120_score", 32'(score), 32'h003);
        chk("t4_120_miss", 32'(misses), 1);
        frame(60'd1 << 59, 9'd500);
        chk("t4_500_miss", 32'(misses), 2);
        chk("t4_go", 32'(game_over), 0);

        // T5: raster with score 001, misses 1
        apply_reset();
        frame(60'd1 << 10, 9'd16);
        frame(60'd1, 9'd16);
        @(negedge clock);
        draw = 1'b1;
        @(posedge clock);
        for (int p = 0; p < 84; p++) begin
            @(posedge clock);
            #1;
            px[p] = x;
            py[p] = y;
            pc[p] = color;
        end
        chk("t5_fin_last", 32'(finish_drawing), 0);
        chk("t5_x0", 32'(px[0]), 128);
        chk("t5_y0", 32'(py[0]), 4);
        chk("t5_c0", 32'(pc[0]), 3'b111);
        chk("t5_c3_gap", 32'(pc[3]), 3'b000);
        chk("t5_c4", 32'(pc[4]), 3'b111);
        chk("t5_x8", 32'(px[8]), 136);
        chk("t5_c8", 32'(pc[8]), 3'b000);
        chk("t5_x9", 32'(px[9]), 137);
        chk("t5_c9", 32'(pc[9]), 3'b111);
        chk("t5_c12", 32'(pc[12]), 3'b111);
        chk("t5_c13", 32'(pc[13]), 3'b000);
        chk("t5_c20", 32'(pc[20]), 3'b111);
        chk("t5_c22", 32'(pc[22]), 3'b000);
        chk("t5_y13", 32'(py[13]), 5);
        chk("t5_c72", 32'(pc[72]), 3'b100);
        chk("t5_c73", 32'(pc[73]), 3'b010);
        chk("t5_c74", 32'(pc[74]), 3'b010);
        chk("t5_c75", 32'(pc[75]), 3'b000);
        chk("t5_x83", 32'(px[83]), 139);
        chk("t5_y83", 32'(py[83]), 10);
        @(posedge clock);
        #1 chk("t5_fin_hi", 32'(finish_drawing), 1);
        @(posedge clock);
        #1 chk("t5_fin_lo", 32'(finish_drawing), 0);
        repeat (10) @(posedge clock);
        #1;
        chk("t5_hold_x", 32'(x), 139);
        chk("t5_hold_y", 32'(y), 10);
        chk("t5_hold_fin", 32'(finish_drawing), 0);
        @(negedge clock);
        draw = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        draw = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("t5_rearm_x", 32'(x), 128);
        chk("t5_rearm_y", 32'(y), 4);
        @(negedge clock);
        draw = 1'b0;
        repeat (83) @(posedge clock);
        #1;
        chk("t5_drop_x", 32'(x), 139);
        chk("t5_drop_y", 32'(y), 10);
        @(posedge clock);
        #1 chk("t5_drop_fin", 32'(finish_drawing), 1);

        // T6: update during scan dropped, resets mid-scan and mid-raster
        apply_reset();
        pulse(60'd1 << 10, 9'd16);
        repeat (4) @(posedge clock);
        pulse(60'd1, 9'd16);
        repeat (55) @(posedge clock);
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_score", 32'(score), 32'h001);
        chk("t6_misses", 32'(misses), 0);
        @(negedge clock);
        draw = 1'b1;
        pulse(60'd1 << 10, 9'd16);
        repeat (10) @(posedge clock);
        #1;
        chk("t6_mid_busy", 32'(busy), 1);
        chk("t6_mid_x", 32'(x), 138);
        #2 reset = 1'b1;
        #1;
        chk("t6_r_x", 32'(x), 0);
        chk("t6_r_y", 32'(y), 0);
        chk("t6_r_score", 32'(score), 0);
        chk("t6_r_busy", 32'(busy), 0);
        chk("t6_r_misses", 32'(misses), 0);
        draw = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        frame(60'd1 << 10, 9'd16);
        chk("t6_clean_score", 32'(score), 32'h001);
        chk("t6_clean_busy", 32'(busy), 0);
        chk("t6_clean_color", 32'(color), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
